// File: rtl/buf_pkg.sv
// +----------------------------------------------------------------------+
// | buf_pkg : shared types for the buffer read-side client.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    REL  = 2'b10,
    ERR  = 2'b11
  } buf_rd_state_t;

  localparam int BUF_RD_QDEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/buf_reader_q.sv
// +----------------------------------------------------------------------+
// | buf_reader_q : 2-entry synchronous output FIFO with head data output. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module buf_reader_q
  import buf_pkg::*;
#(
  parameter int DATA_L = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_L-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic [DATA_L-1:0] head_o,
  output logic              valid_o
);

  logic [DATA_L-1:0] head_q;
  logic [DATA_L-1:0] tail_q;
  logic [1:0]        cnt_q;
  logic              pop;
  logic              push;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign pop  = pop_i && (cnt_q != 2'd0);
  assign push = push_i && ((cnt_q != 2'(BUF_RD_QDEPTH)) || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= push_data_i;
          else               tail_q <= push_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= push_data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ_o   = cnt_q;
  assign head_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);

endmodule

`default_nettype wire

// File: rtl/buf_reader.sv
// +----------------------------------------------------------------------+
// | buf_reader : four-phase read client for the circular buffer, with a  |
// | valid/ready output stream and ack-timeout detection.  Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module buf_reader
  import buf_pkg::*;
#(
  parameter int DATA_L = 16,
  parameter int TMO_L  = 4,
  parameter int CNT_L  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              avail,
  input  logic              r_ack,
  input  logic [DATA_L-1:0] bdata,
  output logic              re,
  output logic [DATA_L-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              err_tmo,
  input  logic              clr_err,
  output logic [CNT_L-1:0]  rd_cnt
);

  buf_rd_state_t     state_q;
  logic              re_q;
  logic              err_q;
  logic [TMO_L-1:0]  tmr_q;
  logic [TMO_L-1:0]  tmr_d;
  logic [CNT_L-1:0]  cnt_q;
  logic [1:0]        occ;
  logic              push;
  logic              issue;
  logic              tmo;

  assign tmr_d = tmr_q + 1'b1;
  assign tmo   = &tmr_d;
  assign push  = (state_q == REQ) && r_ack;

  // In IDLE nothing is in flight, so the occupancy alone bounds the queue.
  assign issue = en && avail && !r_ack && (occ < 2'(BUF_RD_QDEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q <= REQ;
            re_q    <= 1'b1;
            tmr_q   <= '0;
          end
        end
        REQ: begin
          if (r_ack) begin
            state_q <= REL;
            re_q    <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            tmr_q   <= '0;
          end else if (tmo) begin
            state_q <= ERR;
            re_q    <= 1'b0;
            err_q   <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        REL: begin
          if (!r_ack) begin
            state_q <= IDLE;
          end else if (tmo) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        ERR: begin
          re_q <= 1'b0;
          if (clr_err) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  buf_reader_q #(
    .DATA_L (DATA_L)
  ) u_q (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (bdata),
    .pop_i       (dout_ready),
    .occ_o       (occ),
    .head_o      (dout),
    .valid_o     (dout_valid)
  );

  assign re      = re_q;
  assign err_tmo = err_q;
  assign rd_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_buf_reader.sv
// +----------------------------------------------------------------------+
// | tb_buf_reader : directed self-checking bench with a buffer model.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_buf_reader;
  import buf_pkg::*;

  localparam int M_NORM  = 0;
  localparam int M_STUCK = 1;
  localparam int M_NOACK = 2;

  logic        clk = 1'b0;
  logic        rst, en, avail, r_ack, dout_ready, clr_err;
  logic [15:0] bdata;
  logic        re, dout_valid, err_tmo;
  logic [15:0] dout, rd_cnt;
  logic        re4, dout_valid4, err_tmo4;
  logic [15:0] dout4;
  logic [3:0]  rd_cnt4;

  always #5 clk = ~clk;

  buf_reader u_dut (
    .clk(clk), .rst(rst), .en(en), .avail(avail), .r_ack(r_ack), .bdata(bdata),
    .re(re), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_tmo(err_tmo), .clr_err(clr_err), .rd_cnt(rd_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, used for the wrap check.
  buf_reader #(.CNT_L(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .avail(avail), .r_ack(r_ack), .bdata(bdata),
    .re(re4), .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready),
    .err_tmo(err_tmo4), .clr_err(clr_err), .rd_cnt(rd_cnt4)
  );

  typedef struct {
    logic        en;
    logic        rdy;
    logic        e_re;
    logic        e_vld;
    logic [15:0] e_dout;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t        vec [10];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rises = 0;
  int          last_rise = 0;
  int          mode = M_NORM;
  logic        re_prev = 1'b0;
  logic [15:0] bq [$];
  logic [15:0] rx [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    if (dout_valid && dout_ready) rx.push_back(dout);
    @(posedge clk);
    #1;
    cyc++;
    if (re && !re_prev) begin
      rises++;
      last_rise = cyc;
    end
    re_prev = re;
    if (mode == M_NORM || mode == M_STUCK) begin
      if (re && !r_ack) begin
        r_ack = 1'b1;
        if (bq.size() != 0) bdata = bq[0];
      end else if (mode == M_NORM && !re && r_ack) begin
        r_ack = 1'b0;
        if (bq.size() != 0) void'(bq.pop_front());
      end
    end
    avail = (bq.size() != 0);
  endtask

  task automatic load(input logic [15:0] w);
    bq.push_back(w);
    avail = 1'b1;
  endtask

  task automatic wait_rise(input string nm, input int maxc);
    int r0;
    r0 = rises;
    for (int i = 0; i < maxc && rises == r0; i++) step();
    chk(nm, 32'(rises != r0), 32'd1);
  endtask

  task automatic wait_err(input string nm, input int maxc);
    for (int i = 0; i < maxc && !err_tmo; i++) step();
    chk(nm, 32'(err_tmo), 32'd1);
  endtask

  initial begin
    int rc;
    int r0;

    rst = 1'b0; en = 1'b0; avail = 1'b0; r_ack = 1'b0; bdata = '0;
    dout_ready = 1'b1; clr_err = 1'b0;

    vec[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0};
    vec[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 16'd1};
    vec[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd1};
    vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd1};
    vec[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h2222, 16'd2};
    vec[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd2};
    vec[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd2};
    vec[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h3333, 16'd3};
    vec[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd3};
    vec[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd3};

    step(); step();
    chk("rst_re", 32'(re), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_err", 32'(err_tmo), 32'd0);
    chk("rst_cnt", 32'(rd_cnt), 32'd0);
    rst = 1'b1;

    // Three words at full rate: one handshake every 3 cycles.
    load(16'h1111); load(16'h2222); load(16'h3333);
    rx.delete();
    for (int i = 0; i < 10; i++) begin
      en = vec[i].en;
      dout_ready = vec[i].rdy;
      step();
      chk($sformatf("vec%0d_re", i), 32'(re), 32'(vec[i].e_re));
      chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vec[i].e_vld));
      if (vec[i].e_vld) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vec[i].e_dout));
      chk($sformatf("vec%0d_cnt", i), 32'(rd_cnt), 32'(vec[i].e_cnt));
    end
    chk("seq1_rx_n", 32'(rx.size()), 32'd3);
    if (rx.size() == 3) begin
      chk("seq1_rx0", 32'(rx[0]), 32'h1111);
      chk("seq1_rx1", 32'(rx[1]), 32'h2222);
      chk("seq1_rx2", 32'(rx[2]), 32'h3333);
    end

    // Back-pressure: only two handshakes fit in the queue.
    dout_ready = 1'b0;
    rx.delete();
    for (int i = 1; i <= 5; i++) load(16'hA000 + 16'(i));
    r0 = rises;
    repeat (15) step();
    chk("bp_handshakes", 32'(rises - r0), 32'd2);
    chk("bp_re_low", 32'(re), 32'd0);
    chk("bp_valid", 32'(dout_valid), 32'd1);
    chk("bp_dout_hold", 32'(dout), 32'hA001);
    chk("bp_left", 32'(bq.size()), 32'd3);
    dout_ready = 1'b1;
    repeat (20) step();
    chk("bp_rx_n", 32'(rx.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx.size(); i++)
      chk($sformatf("bp_rx%0d", i), 32'(rx[i]), 32'hA001 + 32'(i));
    chk("bp_cnt", 32'(rd_cnt), 32'd8);

    // No acknowledge: timeout from REQ; clr_err held so the timeout must win.
    mode = M_NOACK;
    clr_err = 1'b1;
    load(16'hB001);
    wait_rise("noack_rise", 6);
    rc = last_rise;
    wait_err("noack_err", 40);
    chk("noack_delay", 32'(cyc - rc), 32'd15);
    chk("noack_re", 32'(re), 32'd0);
    chk("noack_cnt", 32'(rd_cnt), 32'd8);
    chk("noack_valid", 32'(dout_valid), 32'd0);
    en = 1'b0;
    step();
    clr_err = 1'b0;
    chk("noack_clr", 32'(err_tmo), 32'd0);
    chk("noack_idle", 32'(u_dut.state_q), 32'(IDLE));

    // Acknowledge stuck high: timeout from REL after one counted read.
    mode = M_STUCK;
    dout_ready = 1'b0;
    en = 1'b1;
    wait_rise("stuck_rise", 6);
    rc = last_rise;
    wait_err("stuck_err", 40);
    chk("stuck_delay", 32'(cyc - rc), 32'd16);
    chk("stuck_cnt", 32'(rd_cnt), 32'd9);
    chk("stuck_re", 32'(re), 32'd0);
    chk("stuck_dout", 32'(dout), 32'hB001);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("stuck_clr", 32'(err_tmo), 32'd0);
    r0 = rises;
    repeat (8) step();
    chk("stuck_no_req", 32'(rises - r0), 32'd0);

    // Asynchronous reset in the middle of a request.
    mode = M_NOACK;
    r_ack = 1'b0;
    wait_rise("rst_mid_rise", 6);
    chk("rst_mid_pre_valid", 32'(dout_valid), 32'd1);
    r_ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_re", 32'(re), 32'd0);
    chk("rst_mid_valid", 32'(dout_valid), 32'd0);
    chk("rst_mid_cnt", 32'(rd_cnt), 32'd0);
    bq.delete();
    load(16'hC001);
    step(); step();
    rst = 1'b1;
    dout_ready = 1'b1;
    re_prev = re;
    r0 = rises;
    repeat (6) step();
    chk("rst_ack_guard", 32'(rises - r0), 32'd0);
    mode = M_NORM;
    r_ack = 1'b0;
    wait_rise("rst_after_ack_low", 6);
    repeat (6) step();
    chk("rst_read_cnt", 32'(rd_cnt), 32'd1);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 14; i++) load(16'hD000 + 16'(i));
    for (int i = 0; i < 60 && (bq.size() != 0 || r_ack); i++) step();
    repeat (3) step();
    chk("wrap_cnt16_pre", 32'(rd_cnt), 32'd15);
    chk("wrap_cnt4_pre", 32'(rd_cnt4), 32'd15);
    load(16'hE001);
    repeat (8) step();
    chk("wrap_cnt16", 32'(rd_cnt), 32'd16);
    chk("wrap_cnt4", 32'(rd_cnt4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buf_reader.md
# buf_reader

Read-side client for the circular `buffer` block. It drives the buffer's `re` / `r_ack` four-phase read handshake and pulls words out whenever `avail` is high. It presents the words downstream on a synchronous valid/ready stream through a 2-entry output queue. It sits between a buffer instance and the consumer stage, so no consumer logic has to handle the buffer's edge-triggered protocol. It also watches for stalled acknowledges.

## Interface
Parameters:
- `DATA_L`, 16, word width; must match the attached buffer's `DATA_L`.
- `TMO_L`, 4, width of the ack-timeout counter; the timeout fires after 2^TMO_L−1 cycles of waiting.
- `CNT_L`, 16, width of the words-read counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (`rst`=0 resets).
- `en`  in  1  read enable; when 0, no new request is issued, and a request already in flight completes.
- `avail`  in  1  buffer non-empty flag.
- `r_ack`  in  1  buffer read acknowledge.
- `bdata`  in  DATA_L  buffer `dout`.
- `re`  out  1  read request to the buffer; registered.
- `dout`  out  DATA_L  head word of the output queue.
- `dout_valid`  out  1  output queue is non-empty.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `err_tmo`  out  1  sticky ack-timeout flag.
- `clr_err`  in  1  clears `err_tmo` and leaves state ERR.
- `rd_cnt`  out  CNT_L  words accepted from the buffer; wraps modulo 2^CNT_L.

## Operation
- States:
  - IDLE (00): no request active.
  - REQ (01): `re` high, waiting for `r_ack` to rise.
  - REL (10): `re` low, waiting for `r_ack` to fall.
  - ERR (11): halted after a timeout.
- IDLE → REQ: requires all of `en`=1, `avail`=1, `r_ack`=0, and (queue occupancy + in-flight) < 2. On the transition, `re`<=1.
- REQ, on `r_ack`=1:
  - push `bdata` into the queue;
  - `rd_cnt`<=`rd_cnt`+1;
  - `re`<=0;
  - go to REL.
- REL → IDLE when `r_ack`=0.
- Timeout: the timer is cleared on entry to REQ and to REL, and increments every cycle spent in either state. When it reaches all-ones:
  - `re`<=0;
  - `err_tmo`<=1;
  - go to ERR.
  - A REQ timeout pushes nothing.
- ERR: `re` stays 0. On `clr_err`=1, `err_tmo`<=0 and the FSM goes to IDLE. The IDLE `r_ack`=0 guard applies after that.
- Output queue, 2 entries:
  - Push and pop in the same cycle are allowed when occupancy is 1 or 2.
  - Occupancy never exceeds 2, because the issue rule counts the in-flight word.
  - `dout` holds its value while `dout_valid`=1 and `dout_ready`=0.
- `avail` is sampled only in IDLE. A drop of `avail` while in REQ is ignored.
- `en` falling in REQ or REL does not abort the handshake.

## Timing
- Reset values: `re`=0, `dout`=0, `dout_valid`=0, `err_tmo`=0, `rd_cnt`=0, state IDLE, queue empty, timer 0.
- Reset mid-handshake forces `re`=0 immediately. After release, the FSM does not issue until `r_ack` has been sampled at 0.
- Latency and throughput:
  - Issue conditions true at edge N gives `re`=1 after N.
  - `r_ack` sampled high at N+1 gives `dout_valid`=1 and `re`=0 after N+1.
  - `r_ack` low at N+2 returns the FSM to IDLE.
  - A new `re` can rise after N+3.
  - Sustained rate: 1 word per 3 cycles.
- `r_ack` is treated as synchronous to `clk`: it is sampled directly with no synchronizer.
- `clr_err` and a timeout in the same cycle: the timeout wins.

## Structure
- Shared package `buf_pkg`: state encoding `buf_rd_state_t` (IDLE, REQ, REL, ERR) and the localparam `BUF_RD_QDEPTH`=2.
- One sub-module, `buf_reader_q`: a 2-entry synchronous FIFO with push/pop, occupancy output and head data output. The FSM, timer and counter stay in `buf_reader`.

## Test plan
- Reset, then the buffer model is preloaded with 0x1111, 0x2222, 0x3333, `en`=1, `dout_ready`=1 → three `re` pulses 3 cycles apart. `dout` shows 0x1111, 0x2222, 0x3333 in order, and `rd_cnt`=3.
- `dout_ready`=0, buffer holds 5 words → exactly 2 handshakes occur, `re` stays 0 afterwards, and `dout` holds the first word. After `dout_ready`=1, the remaining 3 words drain in order.
- The buffer model never raises `r_ack` → `err_tmo`=1 and `re`=0 exactly 15 cycles after `re` rose, with no push. After a `clr_err` pulse, state returns to IDLE.
- `r_ack` stuck high after acknowledge → timeout from REL and `rd_cnt` incremented by exactly 1. After `clr_err`, no new `re` while `r_ack`=1.
- `rst` asserted while `re`=1 → `re`=0 asynchronously and `dout_valid`=0. After release with `r_ack` still 1, there is no request until `r_ack`=0.
- `rd_cnt` preset near wrap (CNT_L=4, 15 reads done), then one more read → `rd_cnt`=0.
